bcd_scan_ctrl: RTL and testbench

- Time-multiplexing scheduler that shares one BCD-to-7-segment decode path across NDIG digit positions of a common-anode display.
- Accepts a packed multi-digit BCD value from the counter datapath via a load/ack handshake, and holds it in a shadow register.
- Commits the shadow value only at frame boundaries, so the display never shows a partly updated value.
- Sits between the BCD counter chain and the board display pins.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_seg7.sv | 28 ++
 rtl/bcd_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the multiplexed BCD display scanner: segment codes
// in gfedcba order and the scan FSM state encoding.
package bcd_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // BLANK: all digits off between digits; SHOW: one digit driven.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/bcd_seg7.sv
// Combinational BCD nibble to 7-segment decoder (gfedcba, active-high).
// Non-decimal nibbles A-F show a dash.
module bcd_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup; anything outside 0-9 falls through to the dash.
    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode display.
// Loads land in a shadow register and are committed to the displayed value
// only at the frame boundary, so a frame never mixes old and new digits.
//
// Handshake: load is a single-cycle request that is always accepted; data is
// captured at the clock edge where load is high and load_ack pulses for one
// cycle afterwards. There is no back-pressure; a later load overwrites the
// shadow value and is acknowledged on its own.
module bcd_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp_sel,
    input  logic              lz_en,
    output logic              load_ack,
    output logic [7:0]        disp,
    output logic [NDIG-1:0]   an,
    output logic              frame_end
);

    localparam int IDX_W = $clog2(NDIG);
    localparam int T_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int T_W   = $clog2(T_MAX + 1);

    localparam logic [T_W-1:0]   DIV_LAST   = T_W'(DIV - 1);
    localparam logic [T_W-1:0]   BLANK_LAST = T_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

    scan_state_e       state_q, state_d;
    logic [T_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [4*NDIG-1:0] active_q, active_d;
    logic              pending_q, pending_d;
    logic              load_ack_q, load_ack_d;
    logic              frame_end_q, frame_end_d;
    logic [7:0]        disp_q, disp_d;
    logic [NDIG-1:0]   an_q, an_d;

    logic [3:0]        nib;
    logic [6:0]        seg;
    logic [NDIG-1:0]   lz_mask;
    logic              zero_run;

    // Scan FSM: BLANK for BLANK_CYC cycles, SHOW for DIV cycles, then next digit.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + T_W'(1);
        idx_d   = idx_q;
        case (state_q)
            BLANK: begin
                if (timer_q == BLANK_LAST) begin
                    state_d = SHOW;
                    timer_d = '0;
                end
            end
            SHOW: begin
                if (timer_q == DIV_LAST) begin
                    state_d = BLANK;
                    timer_d = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = BLANK;
                timer_d = '0;
            end
        endcase
    end

    // Load capture and frame-boundary commit; the commit reads the shadow
    // value held before this edge, so a coincident load stays pending.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        pending_d  = pending_q;
        load_ack_d = load;
        if (frame_end_q && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = data;
            pending_d = 1'b1;
        end
    end

    // Leading-zero mask: digit i is blankable when it and all digits above are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_run   = zero_run & (active_q[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    // Select the nibble for the digit about to be driven into the shared decoder.
    always_comb begin
        nib = active_q[{idx_d, 2'b00} +: 4];
    end

    bcd_seg7 u_seg7 (
        .nib (nib),
        .seg (seg)
    );

    // Registered outputs follow the next state so they line up with state_q.
    always_comb begin
        an_d        = '1;
        disp_d      = 8'h00;
        frame_end_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (timer_d == DIV_LAST);
        if (state_d == SHOW) begin
            an_d   = ~(NDIG'(1) << idx_d);
            disp_d = {dp_sel[idx_d], (lz_en && lz_mask[idx_d]) ? SEG_OFF : seg};
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BLANK;
            timer_q     <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            load_ack_q  <= 1'b0;
            frame_end_q <= 1'b0;
            disp_q      <= 8'h00;
            an_q        <= '1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            load_ack_q  <= load_ack_d;
            frame_end_q <= frame_end_d;
            disp_q      <= disp_d;
            an_q        <= an_d;
        end
    end

    assign load_ack  = load_ack_q;
    assign frame_end = frame_end_q;
    assign disp      = disp_q;
    assign an        = an_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl with NDIG=4, DIV=4, BLANK_CYC=1 (20-cycle frame).
// A cycle-position reference model predicts every output each cycle; a
// vector table and hand sequences pin the documented corner cases.
module tb_bcd_scan_ctrl;

    localparam int NDIG      = 4;
    localparam int DIV       = 4;
    localparam int BLANK_CYC = 1;
    localparam int SLOT      = BLANK_CYC + DIV;
    localparam int FRAME     = NDIG * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_sel;
    logic        lz_en;
    logic        load_ack;
    logic [7:0]  disp;
    logic [3:0]  an;
    logic        frame_end;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic        m_ack;
    logic [6:0]  seg_tab [16];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    // clock
    always #5 clk = ~clk;

    bcd_scan_ctrl #(
        .NDIG      (NDIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data      (data),
        .dp_sel    (dp_sel),
        .lz_en     (lz_en),
        .load_ack  (load_ack),
        .disp      (disp),
        .an        (an),
        .frame_end (frame_end)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
        m_ack     = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs seen at the edge.
    task automatic model_edge();
        if ((m_t % FRAME) == FRAME - 1 && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (load) begin
            m_shadow  = data;
            m_pending = 1'b1;
        end
        m_ack = load;
        m_t++;
    endtask

    // Expected outputs from the position inside the frame.
    task automatic model_expect(output logic [3:0] e_an, output logic [7:0] e_disp,
                                output logic e_fe);
        int pos;
        int d;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic        blank;
        pos  = m_t % FRAME;
        d    = pos / SLOT;
        e_fe = (pos == FRAME - 1);
        if ((pos % SLOT) < BLANK_CYC) begin
            e_an   = 4'hF;
            e_disp = 8'h00;
        end else begin
            e_an   = ~(4'b0001 << d);
            upper  = m_active >> (4 * d);
            nib    = upper[3:0];
            blank  = lz_en && (d > 0) && (upper == 16'h0000);
            e_disp = {dp_sel[d], blank ? 7'h00 : seg_tab[nib]};
        end
    endtask

    // driver: apply load/data, clock once, compare every output to the model
    task automatic tick(input logic ld, input logic [15:0] d);
        logic [3:0] ea;
        logic [7:0] ed;
        logic       ef;
        load = ld;
        data = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_expect(ea, ed, ef);
        check("an", {28'h0, an}, {28'h0, ea});
        check("disp", {24'h0, disp}, {24'h0, ed});
        check("frame_end", {31'h0, frame_end}, {31'h0, ef});
        check("load_ack", {31'h0, load_ack}, {31'h0, m_ack});
    endtask

    task automatic advance_to(input int pos);
        int n;
        n = 0;
        while ((m_t % FRAME) != pos && n < 3 * FRAME) begin
            tick(1'b0, data);
            n++;
        end
        if ((m_t % FRAME) != pos) begin
            checks++;
            errors++;
            $display("FAIL advance_to: position %0d not reached", pos);
        end
    endtask

    // advance to the start of a frame once nothing is left pending
    task automatic advance_clean();
        int n;
        n = 0;
        while (!((m_t % FRAME) == 0 && !m_pending) && n < 4 * FRAME) begin
            tick(1'b0, data);
            n++;
        end
        if (!((m_t % FRAME) == 0 && !m_pending)) begin
            checks++;
            errors++;
            $display("FAIL advance_clean: commit not reached");
        end
    endtask

    task automatic run_vector(input int k);
        logic [3:0] exp_an;
        int d;
        dp_sel = vecs[k].dp;
        lz_en  = vecs[k].lz;
        tick(1'b1, vecs[k].data);
        advance_clean();
        for (int p = 1; p < FRAME; p++) begin
            tick(1'b0, data);
            if ((p % SLOT) != 0) begin
                d      = p / SLOT;
                exp_an = ~(4'b0001 << d);
                check($sformatf("vec%0d_an_d%0d", k, d), {28'h0, an}, {28'h0, exp_an});
                check($sformatf("vec%0d_disp_d%0d", k, d), {24'h0, disp},
                      {24'h0, vecs[k].exp[8*d +: 8]});
            end
        end
    endtask

    initial begin
        int ack_cnt;
        logic ld;

        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;

        // {data, dp_sel, lz_en, expected disp per digit (digit 0 in low byte)}
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'h065B4F66};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 32'h00006D3F};
        vecs[2] = '{16'h0050, 4'b0000, 1'b0, 32'h3F3F6D3F};
        vecs[3] = '{16'h00A0, 4'b0010, 1'b0, 32'h3F3FC03F};
        vecs[4] = '{16'h9876, 4'b1111, 1'b0, 32'hEFFF87FD};
        vecs[5] = '{16'h0000, 4'b0001, 1'b1, 32'h000000BF};
        vecs[6] = '{16'h0F00, 4'b1000, 1'b1, 32'h80403F3F};
        vecs[7] = '{16'hB0C5, 4'b0000, 1'b1, 32'h403F406D};

        // reset
        rst    = 1'b1;
        load   = 1'b0;
        data   = 16'h0000;
        dp_sel = 4'b0000;
        lz_en  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_an", {28'h0, an}, 32'hF);
        check("rst_disp", {24'h0, disp}, 32'h0);
        check("rst_ack", {31'h0, load_ack}, 32'h0);
        check("rst_fe", {31'h0, frame_end}, 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, data);
            check($sformatf("boot_an_%0d", k), {28'h0, an}, (k <= 4) ? 32'hE : 32'hF);
        end

        // table-driven vectors
        for (int k = 0; k < 8; k++) run_vector(k);

        // asynchronous reset in the middle of a SHOW period
        dp_sel = 4'b0000;
        lz_en  = 1'b0;
        advance_to(2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", {28'h0, an}, 32'hF);
        check("async_rst_disp", {24'h0, disp}, 32'h0);
        check("async_rst_ack", {31'h0, load_ack}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, data);
            check($sformatf("rerun_an_%0d", k), {28'h0, an}, (k <= 4) ? 32'hE : 32'hF);
            if (k <= 4) check($sformatf("lost_value_%0d", k), {24'h0, disp}, 32'h3F);
        end

        // two loads in one frame: latest wins, each acknowledged
        advance_clean();
        ack_cnt = 0;
        tick(1'b1, 16'h1111); ack_cnt += int'(load_ack);
        tick(1'b0, data);     ack_cnt += int'(load_ack);
        tick(1'b1, 16'h2222); ack_cnt += int'(load_ack);
        tick(1'b0, data);     ack_cnt += int'(load_ack);
        check("two_loads_acks", ack_cnt, 32'd2);
        advance_clean();
        tick(1'b0, data);
        check("two_loads_d0", {24'h0, disp}, 32'h5B);
        advance_to(FRAME - 4);
        check("two_loads_d3", {24'h0, disp}, 32'h5B);

        // load in the frame_end cycle is held for one more frame
        advance_to(FRAME - 1);
        check("fe_cycle", {31'h0, frame_end}, 32'h1);
        tick(1'b1, 16'h3333);
        tick(1'b0, data);
        check("fe_load_not_yet", {24'h0, disp}, 32'h5B);
        advance_to(0);
        tick(1'b0, data);
        check("fe_load_committed", {24'h0, disp}, 32'h4F);

        // load followed by reset before the frame ends: dropped, no ack afterwards
        advance_to(3);
        tick(1'b1, 16'h7777);
        #2 rst = 1'b1;
        #1;
        check("drop_rst_ack", {31'h0, load_ack}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(1'b0, data);
            ack_cnt += int'(load_ack);
            if ((m_t % FRAME) == 1) check("drop_disp_d0", {24'h0, disp}, 32'h3F);
            if ((m_t % FRAME) == 6) check("drop_disp_d1", {24'h0, disp}, 32'h3F);
        end
        check("drop_no_ack", ack_cnt, 32'd0);

        // randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            dp_sel = 4'($urandom_range(0, 15));
            lz_en  = 1'($urandom_range(0, 1));
            ld     = ($urandom_range(0, 7) == 0);
            tick(ld, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
